// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: control decode, 32x32 register file, load-use stall, ID/EX register
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-before-read on the register file.
module id_stage #(
  parameter bit RF_RESET_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_id_ir,
  input  logic [31:0] if_id_npc,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  output logic [1:0]  id_ex_wb,
  output logic [2:0]  id_ex_m,
  output logic [3:0]  id_ex_ex,
  output logic [31:0] id_ex_npc,
  output logic [31:0] id_ex_rd1,
  output logic [31:0] id_ex_rd2,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd,
  output logic        stall
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [31:0] r_rf [0:31];

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [8:0]  w_ctrl;
  logic        w_we;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_imm;

  assign w_op  = if_id_ir[31:26];
  assign w_rs  = if_id_ir[25:21];
  assign w_rt  = if_id_ir[20:16];
  assign w_imm = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
  assign w_we  = wb_regwrite && (wb_write_reg != 5'd0) && !reset;

  // w_ctrl = {wb[1:0], m[2:0], ex[3:0]}; unknown opcodes decode to an all-zero NOP
  always_comb begin
    w_ctrl = 9'd0;
    case (w_op)
      OP_RTYPE: w_ctrl = {2'b10, 3'b000, 4'b1100};
      OP_LW:    w_ctrl = {2'b11, 3'b010, 4'b0001};
      OP_SW:    w_ctrl = {2'b00, 3'b001, 4'b0001};
      OP_BEQ:   w_ctrl = {2'b00, 3'b100, 4'b0010};
      default:  w_ctrl = 9'd0;
    endcase
  end

`ifdef REGFILE_BYPASS_EN
  assign w_rd1 = (w_rs == 5'd0) ? 32'd0 :
                 (w_we && (wb_write_reg == w_rs)) ? wb_write_data : r_rf[w_rs];
  assign w_rd2 = (w_rt == 5'd0) ? 32'd0 :
                 (w_we && (wb_write_reg == w_rt)) ? wb_write_data : r_rf[w_rt];
`else
  assign w_rd1 = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
  assign w_rd2 = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
`endif

  // Load in ID/EX whose destination feeds the instruction now in IF/ID
  assign stall = id_ex_m[1] && (id_ex_rt != 5'd0) &&
                 ((id_ex_rt == w_rs) || (id_ex_rt == w_rt));

  always_ff @(posedge clk) begin
    if (reset) begin
      if (RF_RESET_CLEAR) begin
        for (int i = 0; i < 32; i++) begin
          r_rf[i] <= 32'd0;
        end
      end
    end else if (w_we) begin
      r_rf[wb_write_reg] <= wb_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_wb  <= 2'd0;
      id_ex_m   <= 3'd0;
      id_ex_ex  <= 4'd0;
      id_ex_npc <= 32'd0;
      id_ex_rd1 <= 32'd0;
      id_ex_rd2 <= 32'd0;
      id_ex_imm <= 32'd0;
      id_ex_rt  <= 5'd0;
      id_ex_rd  <= 5'd0;
    end else begin
      // A stall inserts a bubble: controls cleared, data fields still captured
      {id_ex_wb, id_ex_m, id_ex_ex} <= stall ? 9'd0 : w_ctrl;
      id_ex_npc <= if_id_npc;
      id_ex_rd1 <= w_rd1;
      id_ex_rd2 <= w_rd2;
      id_ex_imm <= w_imm;
      id_ex_rt  <= if_id_ir[20:16];
      id_ex_rd  <= if_id_ir[15:11];
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage against a behavioural decode-stage model
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_npc;
  logic        wb_regwrite;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_rd1;
  logic [31:0] id_ex_rd2;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;
  logic        stall;

  id_stage dut (
    .clk           (clk),
    .reset         (reset),
    .if_id_ir      (if_id_ir),
    .if_id_npc     (if_id_npc),
    .wb_regwrite   (wb_regwrite),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .id_ex_wb      (id_ex_wb),
    .id_ex_m       (id_ex_m),
    .id_ex_ex      (id_ex_ex),
    .id_ex_npc     (id_ex_npc),
    .id_ex_rd1     (id_ex_rd1),
    .id_ex_rd2     (id_ex_rd2),
    .id_ex_imm     (id_ex_imm),
    .id_ex_rt      (id_ex_rt),
    .id_ex_rd      (id_ex_rd),
    .stall         (stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state: architectural registers and the expected ID/EX contents
  logic [31:0] m_rf [0:31];
  logic [1:0]  e_wb;
  logic [2:0]  e_m;
  logic [3:0]  e_ex;
  logic [31:0] e_npc, e_rd1, e_rd2, e_imm;
  logic [4:0]  e_rt, e_rd;
  logic        obs_stall;

  localparam logic [31:0] NOP = 32'hFC00_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] decode(input logic [5:0] op);
    case (op)
      6'h00:   return {2'b10, 3'b000, 4'b1100};
      6'h23:   return {2'b11, 3'b010, 4'b0001};
      6'h2B:   return {2'b00, 3'b001, 4'b0001};
      6'h04:   return {2'b00, 3'b100, 4'b0010};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                          input logic [4:0] wreg, input logic [31:0] wdata);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && wreg == a) return wdata;
`endif
    return m_rf[a];
  endfunction

  task automatic step(input logic rst, input logic [31:0] ir, input logic [31:0] npc,
                      input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
    logic       s;
    logic [8:0] c;
    reset = rst; if_id_ir = ir; if_id_npc = npc;
    wb_regwrite = we; wb_write_reg = wreg; wb_write_data = wdata;
    #1;
    s = e_m[1] && (e_rt != 5'd0) && (e_rt == ir[25:21] || e_rt == ir[20:16]);
    obs_stall = stall;
    if (!rst) check("stall", stall, s);
    if (rst) begin
      {e_wb, e_m, e_ex} = 9'd0;
      e_npc = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0; e_rt = 0; e_rd = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      c = s ? 9'd0 : decode(ir[31:26]);
      e_wb = c[8:7]; e_m = c[6:4]; e_ex = c[3:0];
      e_npc = npc;
      e_rd1 = rf_read(ir[25:21], we, wreg, wdata);
      e_rd2 = rf_read(ir[20:16], we, wreg, wdata);
      e_imm = 32'($signed(ir[15:0]));
      e_rt  = ir[20:16];
      e_rd  = ir[15:11];
      if (we && wreg != 5'd0) m_rf[wreg] = wdata;
    end
    @(posedge clk);
    #1;
    check("wb", id_ex_wb, e_wb);
    check("m", id_ex_m, e_m);
    check("ex", id_ex_ex, e_ex);
    check("npc", id_ex_npc, e_npc);
    check("rd1", id_ex_rd1, e_rd1);
    check("rd2", id_ex_rd2, e_rd2);
    check("imm", id_ex_imm, e_imm);
    check("rt", id_ex_rt, e_rt);
    check("rd", id_ex_rd, e_rd);
  endtask

  initial begin
    logic [31:0] r, ir;
    logic [5:0]  ops [5];
    logic [31:0] exp_byp;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h3F;
    {e_wb, e_m, e_ex} = 9'd0;
    e_rt = 0;

    step(1'b1, NOP, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, NOP, 32'h0, 1'b0, 5'd0, 32'h0);
    check("rst_ctrl", {id_ex_wb, id_ex_m, id_ex_ex}, 9'd0);
    check("rst_stall", stall, 1'b0);

    // load $1 and $4 through writeback, then lw $2,4($1)
    step(1'b0, NOP, 32'h4, 1'b1, 5'd1, 32'h10);
    step(1'b0, NOP, 32'h8, 1'b1, 5'd4, 32'h20);
    step(1'b0, 32'h8C22_0004, 32'hC, 1'b0, 5'd0, 32'h0);
    check("lw_wb", id_ex_wb, 2'b11);
    check("lw_m", id_ex_m, 3'b010);
    check("lw_ex", id_ex_ex, 4'b0001);
    check("lw_rd1", id_ex_rd1, 32'h10);
    check("lw_imm", id_ex_imm, 32'h4);
    check("lw_rt", id_ex_rt, 5'd2);

    // add $3,$2,$4 right behind the load: one bubble, then normal issue
    step(1'b0, 32'h0044_1820, 32'h10, 1'b0, 5'd0, 32'h0);
    check("ldu_stall", obs_stall, 1'b1);
    check("ldu_bubble", {id_ex_wb, id_ex_m, id_ex_ex}, 9'd0);
    step(1'b0, 32'h0044_1820, 32'h10, 1'b0, 5'd0, 32'h0);
    check("ldu_release", obs_stall, 1'b0);
    check("add_ex", id_ex_ex, 4'b1100);

    step(1'b0, 32'h1022_FFFE, 32'h14, 1'b0, 5'd0, 32'h0);
    check("beq_imm", id_ex_imm, 32'hFFFF_FFFE);
    check("beq_m", id_ex_m, 3'b100);

    step(1'b0, NOP, 32'h18, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step(1'b0, 32'h0000_0020, 32'h1C, 1'b0, 5'd0, 32'h0);
    check("r0_rd1", id_ex_rd1, 32'h0);
    check("r0_rd2", id_ex_rd2, 32'h0);

    // same-cycle write and read of $5
    step(1'b0, NOP, 32'h20, 1'b1, 5'd5, 32'h55);
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h1234;
`else
    exp_byp = 32'h55;
`endif
    step(1'b0, 32'h00A0_0020, 32'h24, 1'b1, 5'd5, 32'h1234);
    check("byp_rd1", id_ex_rd1, exp_byp);
    step(1'b0, 32'h00A0_0020, 32'h28, 1'b0, 5'd0, 32'h0);
    check("after_wr_rd1", id_ex_rd1, 32'h1234);

    step(1'b0, NOP, 32'h2C, 1'b0, 5'd0, 32'h0);
    check("op3f_ctrl", {id_ex_wb, id_ex_m, id_ex_ex}, 9'd0);
    check("op3f_stall", obs_stall, 1'b0);

    // reset arriving while a load-use stall is active
    step(1'b0, 32'h8C22_0004, 32'h30, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0044_1820, 32'h34, 1'b0, 5'd0, 32'h0);
    check("rststall_pre", obs_stall, 1'b1);
    check("rststall_ctrl", {id_ex_wb, id_ex_m, id_ex_ex}, 9'd0);
    check("rststall_rd1", id_ex_rd1, 32'h0);
    step(1'b0, 32'h0044_1820, 32'h38, 1'b0, 5'd0, 32'h0);
    check("post_rst_stall", obs_stall, 1'b0);

    // randomized traffic: small register numbers to provoke hazards and write/read collisions
    for (int n = 0; n < 400; n++) begin
      r  = $urandom();
      ir = {ops[$urandom_range(0, 4)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[15:0]};
      r  = $urandom();
      step(($urandom_range(0, 49) == 0), ir, $urandom(), r[0], 5'($urandom_range(0, 7)), $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have parameter RF_RESET_CLEAR, default 1: 1 = reset clears all 32 registers; 0 = reset leaves register contents unchanged.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 The block SHALL have port if_id_ir, input, 32, the instruction from IF/ID.
REQ-005 The block SHALL have port if_id_npc, input, 32, PC+4 from IF/ID.
REQ-006 The block SHALL have port wb_regwrite, input, 1, the writeback enable.
REQ-007 The block SHALL have port wb_write_reg, input, 5, the writeback destination.
REQ-008 The block SHALL have port wb_write_data, input, 32, the writeback data.
REQ-009 The block SHALL have port id_ex_wb, output, 2, encoded {regwrite, memtoreg}.
REQ-010 The block SHALL have port id_ex_m, output, 3, encoded {branch, memread, memwrite}.
REQ-011 The block SHALL have port id_ex_ex, output, 4, encoded {regdst, aluop[1:0], alusrc}.
REQ-012 The block SHALL have ports id_ex_npc, id_ex_rd1, id_ex_rd2 and id_ex_imm, each output, 32.
REQ-013 The block SHALL have ports id_ex_rt and id_ex_rd, each output, 5, carrying ir[20:16] and ir[15:11].
REQ-014 The block SHALL have port stall, output, 1, the combinational load-use hazard flag; while it is high, upstream holds PC and IF/ID.

Function
REQ-015 The block SHALL decode opcode ir[31:26] as follows:
- 0x00 (R-type): ex=1_10_0, m=000, wb=10
- 0x23 (lw): ex=0_00_1, m=010, wb=11
- 0x2B (sw): ex=0_00_1, m=001, wb=00
- 0x04 (beq): ex=0_01_0, m=100, wb=00
- any other opcode: all control bits 0
REQ-016 The register file SHALL hold 32x32 entries, with read ports addressed by ir[25:21] (rs) and ir[20:16] (rt), and with combinational reads.
REQ-017 The register file SHALL write wb_write_data on the rising clk edge when wb_regwrite=1 and wb_write_reg!=0.
REQ-018 Register $0 SHALL always read 0; writes to $0 SHALL be ignored.
REQ-019 id_ex_imm SHALL equal the sign extension of ir[15:0] to 32 bits.
REQ-020 All id_ex_* outputs SHALL be registered and SHALL update on every rising edge, giving a latency of exactly 1 cycle from if_id_ir/if_id_npc.
REQ-021 The stall output SHALL be 1 when id_ex_m[1]=1, id_ex_rt!=0, and id_ex_rt equals rs or rt of the current if_id_ir; otherwise stall SHALL be 0.
REQ-022 When stall=1 at a rising edge, the block SHALL clear id_ex_wb, id_ex_m and id_ex_ex to 0 (bubble) and SHALL still load the data fields.
REQ-023 After a bubble, the hazard SHALL be cleared, so stall SHALL deassert in the next cycle.
REQ-024 An unknown opcode SHALL propagate as a NOP, with no register or memory side effects downstream.

Reset
REQ-025 While reset=1 at a rising edge, all id_ex_* outputs SHALL become 0.
REQ-026 While reset=1 at a rising edge, register-file writes SHALL be suppressed.
REQ-027 While reset=1 at a rising edge, all registers SHALL clear to 0 when RF_RESET_CLEAR=1.
REQ-028 stall SHALL be 0 in the cycle after reset, because id_ex_m is 0.
REQ-029 A reset asserted mid-stall SHALL take priority: the outputs SHALL go to 0 and no bubble logic SHALL apply.

Configuration
REQ-030 With macro REGFILE_BYPASS_EN defined, a read whose address equals wb_write_reg (nonzero, with wb_regwrite=1) in the same cycle SHALL return wb_write_data (write-before-read).
REQ-031 Without REGFILE_BYPASS_EN, such a same-cycle read SHALL return the old register contents; the new value SHALL be visible from the next cycle onward.

Verification
REQ-032 The bench SHALL drive reset for 2 cycles, then if_id_ir=0x8C220004 (lw $2,4($1)) with $1=0x10, and SHALL check one cycle later: wb=11, m=010, ex=0001, rd1=0x10, imm=4, rt=2.
REQ-033 The bench SHALL drive lw $2 followed by add $3,$2,$4 (0x00441820), and SHALL check that stall=1 in the add cycle, the next ID/EX controls are all 0, and stall=0 on the following cycle.
REQ-034 The bench SHALL drive beq with imm 0xFFFE, and SHALL check id_ex_imm=0xFFFFFFFE and m=100.
REQ-035 The bench SHALL write $0 with 0xDEADBEEF, then read $0, and SHALL check that 0 is returned.
REQ-036 The bench SHALL write $5=0x1234 while the same cycle reads rs=5, and SHALL check id_ex_rd1=0x1234 with REGFILE_BYPASS_EN defined and the prior value without it.
REQ-037 The bench SHALL drive opcode 0x3F, and SHALL check that all control outputs are 0 and stall=0.
